prio_arbiter: RTL and testbench
===============================

PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter HOLD_MAX, default 8: maximum grant tenure in cycles (>=1).
REQ-003 SHALL have parameter AGE_LIMIT, default 16: wait cycles before aging promotion (used only with PRIO_ARBITER_AGING_EN).
REQ-004 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, N: request per requester; bit 0 has the highest priority.
REQ-007 SHALL have port done, input, N: owner release strobe, one bit per requester.
REQ-008 SHALL have port gnt, output, N: one-hot grant, all-zero when no owner.
REQ-009 SHALL have port gnt_valid, output, 1: high when gnt is non-zero.
REQ-010 SHALL have port gnt_id, output, $clog2(N): index of current owner, 0 when none.
REQ-011 SHALL have port forced_rel, output, 1: one-cycle pulse when tenure expiry ends a grant.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and GAP, all registered.
REQ-013 IDLE: if req != 0, SHALL register the winner and enter GRANT; gnt is asserted the cycle after req is sampled (latency 1).
REQ-014 Winner SHALL be the lowest set index of req, mutually exclusive, with exactly one winner.
REQ-015 GRANT: the tenure counter SHALL start at 1 on entry and increment each cycle.
REQ-016 GRANT SHALL exit to GAP when done[owner]=1 or req[owner]=0. forced_rel stays 0 for these exits.
REQ-017 GRANT SHALL exit to GAP with forced_rel=1 when the tenure counter equals HOLD_MAX and there is no done exit.
REQ-018 If done and the tenure limit occur in the same cycle, done SHALL take precedence and forced_rel stays 0.
REQ-019 done bits of non-owners SHALL be ignored.
REQ-020 Requests arriving during GRANT SHALL NOT preempt the owner.
REQ-021 GAP SHALL drive gnt=0 for exactly one cycle, then go to IDLE. There are no back-to-back grants.
REQ-022 gnt, gnt_valid and gnt_id SHALL be registered outputs and mutually consistent every cycle.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, forced_rel=0, and clear all counters.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant without a GAP cycle.
REQ-025 After rst_n rises, the first arbitration SHALL occur on the first clk edge with req sampled.

Configuration
REQ-026 Macro PRIO_ARBITER_AGING_EN defined: each requester SHALL keep a wait counter.
  - The counter increments while req[i]=1 and i is not the owner.
  - It clears on grant to i or when req[i]=0.
  - It saturates at AGE_LIMIT.
REQ-027 With PRIO_ARBITER_AGING_EN defined, IDLE SHALL pick the lowest index among aged requesters (counter==AGE_LIMIT) when any is aged, otherwise plain priority.
REQ-028 Macro PRIO_ARBITER_AGING_EN undefined: there SHALL be no wait counters and arbitration is pure fixed priority. The AGE_LIMIT parameter is ignored.

Verification
REQ-029 Bench SHALL cover: req=4'b0110 in IDLE -> next cycle gnt=4'b0010, gnt_id=1, gnt_valid=1.
REQ-030 Bench SHALL cover: owner 1, done=4'b0010 at tenure 3 -> one GAP cycle with gnt=0, then re-arbitration; forced_rel=0.
REQ-031 Bench SHALL cover: HOLD_MAX=8, owner 2 holds req with no done -> gnt drops after 8 grant cycles; forced_rel pulses once.
REQ-032 Bench SHALL cover: done[owner] in the same cycle as tenure 8 -> forced_rel=0.
REQ-033 Bench SHALL cover: rst_n low mid-grant -> gnt=0 asynchronously, before the next clk edge.
REQ-034 Bench SHALL cover, with PRIO_ARBITER_AGING_EN, AGE_LIMIT=16: req=4'b1001 held constant -> requester 3 is granted once its counter reaches 16. Without the macro, requester 3 is never granted.

Source files
------------

// File: rtl/prio_arbiter.sv
// Fixed-priority arbiter with bounded grant tenure and a one-cycle gap
// between grants. Bit 0 of req has the highest priority.
// Optional feature macro: PRIO_ARBITER_AGING_EN adds per-requester wait
// counters so that a starved requester is promoted once it has waited
// AGE_LIMIT cycles.

`ifdef PRIO_ARBITER_AGING_EN
// Per-requester wait counter; saturates at AGE_LIMIT and flags "aged".
module prio_arbiter_age_ctr #(
    parameter int AGE_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_owner,
    input  logic i_win,
    output logic o_aged
);
    localparam int CW = $clog2(AGE_LIMIT + 1);

    logic [CW-1:0] r_cnt;

    // Count waiting cycles; a grant or a dropped request starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!i_req || i_win)
            r_cnt <= '0;
        else if (!i_owner && r_cnt != CW'(AGE_LIMIT))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_aged = (r_cnt == CW'(AGE_LIMIT));
endmodule
`endif

module prio_arbiter #(
    parameter int N         = 4,
    parameter int HOLD_MAX  = 8,
    parameter int AGE_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 forced_rel
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_id, w_id_nxt;
    logic          r_vld, w_vld_nxt;
    logic          r_frel, w_frel_nxt;
    logic [TW-1:0] r_ten, w_ten_nxt;
    logic [N-1:0]  w_pick;
    logic          w_own_done;
    logic          w_own_req;

    // Isolate the lowest set bit.
    function automatic logic [N-1:0] f_lsb(input logic [N-1:0] v);
        return v & (~v + 1'b1);
    endfunction

    // Index of a one-hot vector.
    function automatic logic [IW-1:0] f_idx(input logic [N-1:0] v);
        f_idx = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) f_idx = IW'(i);
    endfunction

`ifdef PRIO_ARBITER_AGING_EN
    logic [N-1:0] w_aged;
    logic [N-1:0] w_win;
    logic [N-1:0] w_aged_req;

    assign w_win      = (r_state == S_IDLE) ? w_pick : '0;
    assign w_aged_req = w_aged & req;
    // Aged requesters outrank plain priority.
    assign w_pick     = f_lsb((|w_aged_req) ? w_aged_req : req);

    for (genvar g = 0; g < N; g++) begin : g_age
        prio_arbiter_age_ctr #(.AGE_LIMIT(AGE_LIMIT)) u_age (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_req   (req[g]),
            .i_owner (r_gnt[g]),
            .i_win   (w_win[g]),
            .o_aged  (w_aged[g])
        );
    end
`else
    logic w_unused_age;
    assign w_unused_age = (AGE_LIMIT != 0);
    assign w_pick       = f_lsb(req);
`endif

    // Only the owner's done/req bits matter; other done bits are ignored.
    assign w_own_done = |(done & r_gnt);
    assign w_own_req  = |(req & r_gnt);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_id;
        w_vld_nxt   = r_vld;
        w_frel_nxt  = 1'b0;
        w_ten_nxt   = r_ten;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = w_pick;
                    w_id_nxt    = f_idx(w_pick);
                    w_vld_nxt   = 1'b1;
                    w_ten_nxt   = TW'(1);
                end
            end
            S_GRANT: begin
                if (w_own_done || !w_own_req || r_ten == TW'(HOLD_MAX)) begin
                    // done wins over tenure expiry for forced_rel.
                    w_frel_nxt  = !w_own_done && w_own_req;
                    w_state_nxt = S_GAP;
                    w_gnt_nxt   = '0;
                    w_id_nxt    = '0;
                    w_vld_nxt   = 1'b0;
                    w_ten_nxt   = '0;
                end else begin
                    w_ten_nxt = r_ten + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_id_nxt    = '0;
                w_vld_nxt   = 1'b0;
                w_ten_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_vld   <= 1'b0;
            r_frel  <= 1'b0;
            r_ten   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_id    <= w_id_nxt;
            r_vld   <= w_vld_nxt;
            r_frel  <= w_frel_nxt;
            r_ten   <= w_ten_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign gnt_valid  = r_vld;
    assign gnt_id     = r_id;
    assign forced_rel = r_frel;
endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=4, HOLD_MAX=8, AGE_LIMIT=16).
module tb_prio_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       forced_rel;

    int n_chk  = 0;
    int n_fail = 0;
    int n_bad  = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    prio_arbiter #(.N(4), .HOLD_MAX(8), .AGE_LIMIT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .forced_rel (forced_rel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Output consistency: valid iff non-zero, one-hot, id matches.
    always @(negedge clk) begin
        if (gnt_valid !== (gnt != 4'b0)) n_bad++;
        if ((gnt & (gnt - 4'd1)) != 4'b0) n_bad++;
        if (gnt_valid && gnt[gnt_id] !== 1'b1) n_bad++;
        if (!gnt_valid && gnt_id != 2'd0) n_bad++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_gnt"}, int'(gnt), int'(e.gnt));
            chk({name, "_id"}, int'(gnt_id), int'(e.id));
            chk({name, "_vld"}, int'(gnt_valid), int'(e.vld));
        end
    endtask

    initial begin
        int   cnt;
        int   frel_cnt;
        bit   seen3;
        exp_t e;

        vecs[0] = '{4'b0110, 4'b0010, 2'd1};
        vecs[1] = '{4'b0001, 4'b0001, 2'd0};
        vecs[2] = '{4'b1000, 4'b1000, 2'd3};
        vecs[3] = '{4'b1111, 4'b0001, 2'd0};
        vecs[4] = '{4'b1100, 4'b0100, 2'd2};
        vecs[5] = '{4'b1010, 4'b0010, 2'd1};
        vecs[6] = '{4'b0100, 4'b0100, 2'd2};
        vecs[7] = '{4'b0000, 4'b0000, 2'd0};

        rst_n = 1'b0;
        req   = 4'b0;
        done  = 4'b0;
        cyc();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_vld", int'(gnt_valid), 0);
        chk("rst_id", int'(gnt_id), 0);
        chk("rst_frel", int'(forced_rel), 0);
        cyc();
        #2 rst_n = 1'b1;

        // Single-shot arbitration from IDLE, latency 1.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            e.gnt = vecs[i].gnt;
            e.id  = vecs[i].id;
            e.vld = (vecs[i].gnt != 4'b0);
            sb.push_back(e);
            cyc();
            sb_check($sformatf("vec%0d", i));
            req = 4'b0;
            cyc();
            chk($sformatf("vec%0d_gap_gnt", i), int'(gnt), 0);
            chk($sformatf("vec%0d_gap_frel", i), int'(forced_rel), 0);
            cyc();
            cyc();
        end

        // Owner 1 releases with done at tenure 3.
        req = 4'b0110;
        cyc();
        chk("done3_gnt", int'(gnt), 4'b0010);
        cyc();
        cyc();
        chk("done3_t3_gnt", int'(gnt), 4'b0010);
        done = 4'b0010;
        cyc();
        done = 4'b0;
        chk("done3_gap_gnt", int'(gnt), 0);
        chk("done3_gap_frel", int'(forced_rel), 0);
        cyc();
        chk("done3_idle_gnt", int'(gnt), 0);
        chk("done3_idle_frel", int'(forced_rel), 0);
        e = '{4'b0010, 2'd1, 1'b1};
        sb.push_back(e);
        cyc();
        sb_check("done3_rearb");
        req = 4'b0;
        cyc();
        cyc();

        // Owner 2 holds with no done: tenure expiry after 8 cycles.
        req = 4'b0100;
        cyc();
        cnt = 0;
        frel_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (forced_rel) frel_cnt++;
            if (gnt != 4'b0100) break;
            cnt++;
            cyc();
        end
        chk("hold_cycles", cnt, 8);
        chk("hold_frel_at_drop", int'(forced_rel), 1);
        cyc();
        if (forced_rel) frel_cnt++;
        chk("hold_idle_gnt", int'(gnt), 0);
        chk("hold_frel_pulses", frel_cnt, 1);
        cyc();
        chk("hold_regrant", int'(gnt), 4'b0100);
        chk("hold_regrant_frel", int'(forced_rel), 0);
        req = 4'b0;
        cyc();
        cyc();

        // done at tenure 8; also non-owner done and late request ignored.
        req = 4'b0100;
        cyc();
        done = 4'b0001;
        cyc();
        done = 4'b0;
        chk("nonowner_done_gnt", int'(gnt), 4'b0100);
        req = 4'b0101;
        cyc();
        chk("no_preempt_gnt", int'(gnt), 4'b0100);
        for (int k = 0; k < 5; k++) cyc();
        chk("t8_gnt", int'(gnt), 4'b0100);
        done = 4'b0100;
        cyc();
        done = 4'b0;
        chk("t8_done_gnt", int'(gnt), 0);
        chk("t8_done_frel", int'(forced_rel), 0);
        req = 4'b0;
        cyc();
        cyc();

        // Asynchronous reset mid-grant, then immediate re-arbitration.
        req = 4'b0001;
        cyc();
        chk("arst_pre_gnt", int'(gnt), 4'b0001);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_vld", int'(gnt_valid), 0);
        chk("arst_id", int'(gnt_id), 0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        chk("arst_first_arb", int'(gnt), 4'b0001);

        // Starvation of requester 3 under constant req=1001.
        req = 4'b0;
        rst_n = 1'b0;
        cyc();
        #2 rst_n = 1'b1;
        req = 4'b1001;
        seen3 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cyc();
            if (gnt == 4'b1000) seen3 = 1'b1;
        end
`ifdef PRIO_ARBITER_AGING_EN
        chk("aging_req3_granted", int'(seen3), 1);
`else
        chk("noaging_req3_never", int'(seen3), 0);
`endif
        req = 4'b0;
        cyc();
        cyc();

        chk("consistency_errors", n_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
